fir_input_sequencer: RTL

// - Upstream stage of the FIR controller. Buffers incoming samples and coefficient

---
 rtl/fir_input_sequencer.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/fir_input_sequencer.sv
// FIR input sequencer: buffers stream samples and host coefficient writes and turns them
// into the controller's dr/lc request handshake, presenting the operand on data_out.
// Optional watchdog on the controller handshake is enabled with SEQ_TIMEOUT_EN.
module fir_input_sequencer #(
  parameter int unsigned DW     = 16,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned NCOEFF = 4,
  parameter int unsigned TMO    = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_valid,
  input  logic [DW-1:0]              s_data,
  output logic                       s_ready,
  input  logic                       c_valid,
  input  logic [DW-1:0]              c_data,
  output logic                       c_ready,
  input  logic                       modwait,
  input  logic                       err,
  input  logic                       err_clr,
  output logic                       dr,
  output logic                       lc,
  output logic [DW-1:0]              data_out,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       coeff_busy,
  output logic                       err_sticky,
  output logic [7:0]                 err_count,
  output logic                       timeout
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned GW = $clog2(NCOEFF + 1);

  typedef enum logic [2:0] {
    StIdle, StDrReq, StDrHold, StDrWait, StLcReq, StLcHold, StLcWait
  } state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   fifo_mem [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            slot_full_q;
  logic [DW-1:0]   slot_data_q;
  logic [GW-1:0]   grp_cnt_q;
  logic [DW-1:0]   data_out_q;
  logic            err_q, err_sticky_q;
  logic [7:0]      err_count_q;

  logic fifo_full, fifo_empty, push, pop, coeff_take;
  logic load_sample, load_coeff, grp_inc, err_rise, tmo_fire;

  assign fifo_full  = (count_q == CW'(DEPTH));
  assign fifo_empty = (count_q == '0);
  assign push       = s_valid && !fifo_full;
  assign pop        = load_sample;
  assign coeff_take = c_valid && !slot_full_q;
  assign err_rise   = err && !err_q;

`ifdef SEQ_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TMO + 1);
  logic [TW-1:0] wd_q;
  logic          timeout_q;
  logic          watched;

  assign watched  = (state_q == StDrReq) || (state_q == StDrWait) ||
                    (state_q == StLcReq) || (state_q == StLcWait);
  assign tmo_fire = watched && (wd_q == TW'(TMO - 1));

  // Watchdog counts cycles spent in one watched state; any state change restarts it
  always_ff @(posedge clk) begin
    if (rst || (state_d != state_q) || !watched) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_q + TW'(1);
    end
  end

  // Timeout flag: set on expiry, held until reset or err_clr
  always_ff @(posedge clk) begin
    if (rst) begin
      timeout_q <= 1'b0;
    end else if (tmo_fire) begin
      timeout_q <= 1'b1;
    end else if (err_clr) begin
      timeout_q <= 1'b0;
    end
  end

  assign timeout = timeout_q;
`else
  logic [31:0] unused_tmo;
  assign unused_tmo = TMO;
  assign tmo_fire   = 1'b0;
  assign timeout    = 1'b0;
`endif

  // Next-state and request decode; coefficients win over samples in IDLE
  always_comb begin
    state_d     = state_q;
    load_sample = 1'b0;
    load_coeff  = 1'b0;
    grp_inc     = 1'b0;
    case (state_q)
      StIdle: begin
        if (!modwait) begin
          if (slot_full_q) begin
            load_coeff = 1'b1;
            state_d    = StLcReq;
          end else if (!fifo_empty && (grp_cnt_q == '0)) begin
            load_sample = 1'b1;
            state_d     = StDrReq;
          end
        end
      end
      StDrReq:  if (modwait) state_d = StDrHold;
      StDrHold: state_d = StDrWait;
      StDrWait: if (!modwait) state_d = StIdle;
      StLcReq:  if (modwait) state_d = StLcHold;
      StLcHold: state_d = StLcWait;
      StLcWait: begin
        if (!modwait) begin
          grp_inc = 1'b1;
          state_d = StIdle;
        end
      end
      default:  state_d = StIdle;
    endcase
    // Expiry abandons the request; an abandoned coefficient does not advance the group
    if (tmo_fire) begin
      state_d = StIdle;
      grp_inc = 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Sample FIFO storage (data only, no reset needed)
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= s_data;
  end

  // Sample FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (!push && pop) count_q <= count_q - CW'(1);
    end
  end

  // Single-entry coefficient slot; it can only refill once empty, so take and free never overlap
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_full_q <= 1'b0;
      slot_data_q <= '0;
    end else if (coeff_take) begin
      slot_full_q <= 1'b1;
      slot_data_q <= c_data;
    end else if (load_coeff) begin
      slot_full_q <= 1'b0;
    end
  end

  // Coefficient group position, wraps after a full group
  always_ff @(posedge clk) begin
    if (rst) begin
      grp_cnt_q <= '0;
    end else if (grp_inc) begin
      grp_cnt_q <= (grp_cnt_q == GW'(NCOEFF - 1)) ? '0 : grp_cnt_q + GW'(1);
    end
  end

  // Operand register, held for the whole request
  always_ff @(posedge clk) begin
    if (rst || tmo_fire)  data_out_q <= '0;
    else if (load_coeff)  data_out_q <= slot_data_q;
    else if (load_sample) data_out_q <= fifo_mem[rd_ptr_q];
  end

  // Error edge recording; clear beats a coincident edge, and err_q keeps tracking
  // so a level that persists past the clear is not counted again
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q        <= 1'b0;
      err_sticky_q <= 1'b0;
      err_count_q  <= '0;
    end else begin
      err_q <= err;
      if (err_clr) begin
        err_sticky_q <= 1'b0;
        err_count_q  <= '0;
      end else if (err_rise) begin
        err_sticky_q <= 1'b1;
        if (err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;
      end
    end
  end

  assign s_ready    = !fifo_full;
  assign c_ready    = !slot_full_q;
  assign dr         = (state_q == StDrReq) || (state_q == StDrHold);
  assign lc         = (state_q == StLcReq) || (state_q == StLcHold);
  assign data_out   = data_out_q;
  assign fifo_count = count_q;
  assign coeff_busy = (grp_cnt_q != '0) || (state_q == StLcReq) ||
                      (state_q == StLcHold) || (state_q == StLcWait);
  assign err_sticky = err_sticky_q;
  assign err_count  = err_count_q;

endmodule
